// File: rtl/spu_alu_pkg.sv
// Shared types for the SPU SIMD ALU: opcodes, element sizes, FSM state and the
// per-element operation helper used by every 32-bit slice.
package spu_alu_pkg;

    localparam int LANE_SLICE = 32;

    typedef enum logic [3:0] {
        OP_SUB = 4'b0000,
        OP_ADD = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SHL = 4'b0101,
        OP_SHR = 4'b0110,
        OP_MUL = 4'b0111,
        OP_CEQ = 4'b1000
    } op_e;

    typedef enum logic [1:0] {
        ES_BYTE = 2'b00,
        ES_HALF = 2'b01,
        ES_WORD = 2'b10,
        ES_RSVD = 2'b11
    } esize_e;

    typedef logic [0:0] state_e;
    localparam state_e IDLE     = 1'b0;
    localparam state_e MUL_BUSY = 1'b1;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= 4'b1000;
    endfunction

    // Operands arrive zero-extended to 32 bits; n is the element width (8/16/32)
    // and the result is masked back down to it.
    function automatic logic [31:0] lane_op(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic [5:0] n);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (n == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        case (op)
            OP_SUB:  r = x - y;
            OP_ADD:  r = x + y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SHL:  r = (y >= {26'd0, n}) ? 32'd0 : (x << y[4:0]);
            OP_SHR:  r = (y >= {26'd0, n}) ? 32'd0 : (x >> y[4:0]);
            OP_MUL:  r = x * y;
            OP_CEQ:  r = (x == y) ? 32'hFFFF_FFFF : 32'd0;
            default: r = 32'd0;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/spu_simd_alu_if.sv
// Issue/writeback bundle of the SPU SIMD ALU.
// Valid/ready: a transfer occurs on any rising edge where valid && ready; the
// sender holds its payload stable while valid is high and ready is low.
interface spu_simd_alu_if #(
    parameter int WIDTH = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [1:0]       esize;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero_signal;
    logic             err;
    logic             state_dbg;

    modport master (
        output in_valid, alu_op, esize, a, b, out_ready,
        input  in_ready, out_valid, result, zero_signal, err, state_dbg
    );

    modport slave (
        input  in_valid, alu_op, esize, a, b, out_ready,
        output in_ready, out_valid, result, zero_signal, err, state_dbg
    );
endinterface

// File: rtl/spu_simd_lane.sv
// One combinational 32-bit slice: 4x8, 2x16 or 1x32 elements selected by esize.
module spu_simd_lane
    import spu_alu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  esize,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res
);

    logic [31:0] tmp;

    always_comb begin
        res = '0;
        tmp = '0;
        case (esize)
            ES_BYTE: begin
                for (int i = 0; i < 4; i++) begin
                    tmp = lane_op(op, {24'd0, a[8*i +: 8]}, {24'd0, b[8*i +: 8]}, 6'd8);
                    res[8*i +: 8] = tmp[7:0];
                end
            end
            ES_HALF: begin
                for (int i = 0; i < 2; i++) begin
                    tmp = lane_op(op, {16'd0, a[16*i +: 16]}, {16'd0, b[16*i +: 16]}, 6'd16);
                    res[16*i +: 16] = tmp[15:0];
                end
            end
            ES_WORD: res = lane_op(op, a, b, 6'd32);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/spu_simd_alu.sv
// Pipelined SIMD ALU: single-cycle lane ops plus a MUL_LAT-cycle multiply,
// with a one-deep registered output stage between issue and writeback.
module spu_simd_alu
    import spu_alu_pkg::*;
#(
    parameter int WIDTH   = 128,
    parameter int MUL_LAT = 3
) (
    input logic            clk,
    input logic            rst_n,
    spu_simd_alu_if.slave  bus
);

    localparam int NSLICE = WIDTH / LANE_SLICE;
    localparam int CNT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       esize_q, esize_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             busy;
    logic             accept;
    logic             legal;
    logic             is_mul;
    logic [3:0]       lane_op_sel;
    logic [1:0]       lane_esize;
    logic [WIDTH-1:0] lane_a, lane_b, lane_res;

    assign busy   = (state_q == MUL_BUSY);
    assign legal  = op_legal(bus.alu_op) && (bus.esize != ES_RSVD);
    assign is_mul = legal && (bus.alu_op == OP_MUL);

    assign bus.in_ready = rst_n && !busy && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // While a multiply is in flight the slices see the captured operands.
    assign lane_op_sel = busy ? OP_MUL  : bus.alu_op;
    assign lane_esize  = busy ? esize_q : bus.esize;
    assign lane_a      = busy ? a_q     : bus.a;
    assign lane_b      = busy ? b_q     : bus.b;

    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        spu_simd_lane u_lane (
            .op    (lane_op_sel),
            .esize (lane_esize),
            .a     (lane_a[LANE_SLICE*g +: LANE_SLICE]),
            .b     (lane_b[LANE_SLICE*g +: LANE_SLICE]),
            .res   (lane_res[LANE_SLICE*g +: LANE_SLICE])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        esize_d     = esize_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        err_d       = err_q;

        if (state_q == IDLE) begin
            if (accept) begin
                if (is_mul && (MUL_LAT > 1)) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    esize_d = bus.esize;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                    state_d = MUL_BUSY;
                end else begin
                    out_valid_d = 1'b1;
                    result_d    = legal ? lane_res : '0;
                    zero_d      = legal ? (lane_res == '0) : 1'b1;
                    err_d       = !legal;
                end
            end
        end else begin
            // The counter counts the busy cycles still to come; the product is
            // registered on the edge leaving the last one, MUL_LAT edges after accept.
            if (cnt_q == '0) begin
                out_valid_d = 1'b1;
                result_d    = lane_res;
                zero_d      = (lane_res == '0);
                err_d       = 1'b0;
                state_d     = IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            esize_q     <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            esize_q     <= esize_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.zero_signal = zero_q;
    assign bus.err         = err_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_spu_simd_alu.sv
// Directed bench for spu_simd_alu: hand-computed vectors checked with immediate
// assertions, covering latency, backpressure, reset and error handling.
module tb_spu_simd_alu;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    spu_simd_alu_if #(.WIDTH(128)) bus ();

    spu_simd_alu #(.WIDTH(128), .MUL_LAT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] es,
                         input logic [127:0] a, input logic [127:0] b);
        bus.alu_op   = op;
        bus.esize    = es;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
    endtask

    // Present one op, confirm it is accepted on the next edge, then drop valid.
    task automatic issue(input string tag, input logic [3:0] op, input logic [1:0] es,
                         input logic [127:0] a, input logic [127:0] b);
        drive(op, es, a, b);
        chk({tag, "_in_ready"}, {127'd0, bus.in_ready}, 128'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [127:0] res, input logic zero,
                           input logic err);
        chk({tag, "_valid"}, {127'd0, bus.out_valid}, 128'd1);
        chk({tag, "_result"}, bus.result, res);
        chk({tag, "_zero"}, {127'd0, bus.zero_signal}, {127'd0, zero});
        chk({tag, "_err"}, {127'd0, bus.err}, {127'd0, err});
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_op    = 4'd0;
        bus.esize     = 2'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", {127'd0, bus.in_ready}, 128'd0);
        chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("rst_result", bus.result, 128'd0);
        chk("rst_zero", {127'd0, bus.zero_signal}, 128'd0);
        chk("rst_err", {127'd0, bus.err}, 128'd0);
        chk("rst_state", {127'd0, bus.state_dbg}, 128'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {127'd0, bus.in_ready}, 128'd1);

        // ADD byte wraps within the lane; then back-to-back ADD word carries
        drive(4'b0001, 2'b00, 128'hFF, 128'h01);
        tick();
        chk_out("add_b", 128'h0, 1'b1, 1'b0);
        chk("b2b_in_ready", {127'd0, bus.in_ready}, 128'd1);
        drive(4'b0001, 2'b10, 128'hFF, 128'h01);
        tick();
        bus.in_valid = 1'b0;
        chk_out("add_w", 128'h100, 1'b0, 1'b0);
        tick();
        chk("add_retired", {127'd0, bus.out_valid}, 128'd0);

        // SUB byte: no borrow leaks into byte 1
        issue("sub_b", 4'b0000, 2'b00, 128'h00, 128'h01);
        chk_out("sub_b", 128'hFF, 1'b0, 1'b0);

        // MUL halfword: 0x100*0x100 wraps to 0; MUL_LAT=3 edges
        issue("mul_h", 4'b0111, 2'b01, 128'h0100, 128'h0100);
        chk("mul_h_c0_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("mul_h_c0_state", {127'd0, bus.state_dbg}, 128'd1);
        tick();
        chk("mul_h_c1_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("mul_h_c1_in_ready", {127'd0, bus.in_ready}, 128'd0);
        tick();
        chk("mul_h_c2_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("mul_h_c2_in_ready", {127'd0, bus.in_ready}, 128'd0);
        tick();
        chk_out("mul_h", 128'h0, 1'b1, 1'b0);

        // MUL word, with an ADD held on in_valid during the busy window
        issue("mul_w", 4'b0111, 2'b10, 128'h0100, 128'h0100);
        drive(4'b0001, 2'b10, 128'h1, 128'h1);
        tick();
        chk("mul_w_c1_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("mul_w_c1_in_ready", {127'd0, bus.in_ready}, 128'd0);
        tick();
        chk("mul_w_c2_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("mul_w_c2_in_ready", {127'd0, bus.in_ready}, 128'd0);
        bus.in_valid = 1'b0;
        tick();
        chk_out("mul_w", 128'h10000, 1'b0, 1'b0);
        tick();
        chk("mul_w_ignored_add", {127'd0, bus.out_valid}, 128'd0);

        // CEQ word: words 0, 2, 3 equal, word 1 differs
        issue("ceq_w", 4'b1000, 2'b10, 128'h5_0000_0007, 128'h7_0000_0007);
        chk_out("ceq_w", 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF, 1'b0, 1'b0);

        // SHL byte: shift 1 and shift 8 (>= lane width gives 0)
        issue("shl_b", 4'b0101, 2'b00, 128'h0101, 128'h0801);
        chk_out("shl_b", 128'h02, 1'b0, 1'b0);

        // SHR word: shift 31 and shift 32
        issue("shr_w", 4'b0110, 2'b10, 128'hFFFFFFFF_80000000, 128'h20_0000001F);
        chk_out("shr_w", 128'h1, 1'b0, 1'b0);

        // Backpressure: hold the XOR result 4 cycles with an AND waiting
        tick();
        bus.out_ready = 1'b0;
        issue("bp_xor", 4'b0100, 2'b00, 128'hF0F0, 128'hFF00);
        drive(4'b0010, 2'b10, 128'hF, 128'h3);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_valid", {127'd0, bus.out_valid}, 128'd1);
            chk("bp_hold_result", bus.result, 128'h0FF0);
            chk("bp_hold_in_ready", {127'd0, bus.in_ready}, 128'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {127'd0, bus.in_ready}, 128'd1);
        tick();
        bus.in_valid = 1'b0;
        chk_out("bp_and", 128'h3, 1'b0, 1'b0);
        tick();
        chk("bp_retired", {127'd0, bus.out_valid}, 128'd0);

        // Reset one cycle into a multiply discards it
        issue("rst_mul", 4'b0111, 2'b10, 128'h2, 128'h3);
        rst_n = 1'b0;
        #1;
        chk("rst_mul_in_ready", {127'd0, bus.in_ready}, 128'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_mul_valid", {127'd0, bus.out_valid}, 128'd0);
            chk("rst_mul_result", bus.result, 128'd0);
            chk("rst_mul_zero", {127'd0, bus.zero_signal}, 128'd0);
            chk("rst_mul_err", {127'd0, bus.err}, 128'd0);
            tick();
        end
        issue("post_rst_add", 4'b0001, 2'b10, 128'h2, 128'h3);
        chk_out("post_rst_add", 128'h5, 1'b0, 1'b0);

        // Illegal opcode, reserved esize, then a legal op clears err
        issue("illegal_op", 4'b1111, 2'b00, 128'h1, 128'h1);
        chk_out("illegal_op", 128'h0, 1'b1, 1'b1);
        issue("rsvd_esize", 4'b0011, 2'b11, 128'h1, 128'h1);
        chk_out("rsvd_esize", 128'h0, 1'b1, 1'b1);
        issue("or_clear", 4'b0011, 2'b00, 128'h10, 128'h01);
        chk_out("or_clear", 128'h11, 1'b0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
